// File: rtl/dsp_decim_fifo.sv
// Decimating sample FIFO: keeps 1 of every N filtered samples and buffers them for bus-side pops.
// Optional drop counter output enabled by defining DSP_DECIM_FIFO_DROP_CNT_EN.
module dsp_decim_fifo #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic [7:0]    decim_factor,
  input  logic [AW:0]   threshold,
  input  logic          in_valid,
  input  logic [15:0]   in_sample,
  input  logic          rd_en,
  output logic          rd_valid,
  output logic [15:0]   rd_data,
  output logic [AW:0]   level,
  output logic          empty,
  output logic          full,
  output logic          thr_flag,
  output logic          ovf,
`ifdef DSP_DECIM_FIFO_DROP_CNT_EN
  output logic [15:0]   drop_cnt,
`endif
  input  logic          ovf_clr
);

  localparam logic [AW:0] LevelFull = (AW + 1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [7:0]    dcnt_q, dcnt_d;
  logic          rd_valid_q, rd_valid_d;
  logic [15:0]   rd_data_q, rd_data_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   mem_q [DEPTH];

  logic [7:0] eff_n;
  logic       keep;
  logic       push;
  logic       pop;
  logic       drop;

  // Status flags come straight from the registered occupancy.
  always_comb begin
    empty    = (level_q == '0);
    full     = (level_q == LevelFull);
    thr_flag = (threshold != '0) && (level_q >= threshold);
  end

  // A factor of 0 behaves as 1 so the block never stalls on a bad CSR value.
  always_comb begin
    eff_n = (decim_factor == 8'd0) ? 8'd1 : decim_factor;
    keep  = enable && in_valid && (dcnt_q == 8'd0);
    pop   = enable && rd_en && !empty;
    push  = keep && (!full || pop);
    drop  = keep && full && !pop;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    dcnt_d     = dcnt_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    ovf_d      = ovf_q;

    if (!enable) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      dcnt_d   = 8'd0;
    end else begin
      // >= rather than == lets a shrunk factor wrap on the very next sample.
      if (in_valid) begin
        dcnt_d = (dcnt_q >= eff_n - 8'd1) ? 8'd0 : dcnt_q + 8'd1;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d   = rd_ptr_q + 1'b1;
        rd_valid_d = 1'b1;
        rd_data_d  = mem_q[rd_ptr_q];
      end
      case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end

    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      dcnt_q     <= 8'd0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 16'd0;
      ovf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      dcnt_q     <= dcnt_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      ovf_q      <= ovf_d;
    end
  end

  // Storage has no reset; contents are only observable after a push.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_sample;
    end
  end

`ifdef DSP_DECIM_FIFO_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // A drop in the same cycle as a clear leaves the count at one.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      if (ovf_clr) begin
        drop_cnt_d = 16'd1;
      end else if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end else if (ovf_clr) begin
      drop_cnt_d = 16'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= 16'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign level    = level_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_dsp_decim_fifo.sv
// Self-checking bench for dsp_decim_fifo: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_dsp_decim_fifo;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic [7:0]    decim_factor;
  logic [AW:0]   threshold;
  logic          in_valid;
  logic [15:0]   in_sample;
  logic          rd_en;
  logic          rd_valid;
  logic [15:0]   rd_data;
  logic [AW:0]   level;
  logic          empty;
  logic          full;
  logic          thr_flag;
  logic          ovf;
  logic          ovf_clr;
`ifdef DSP_DECIM_FIFO_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  int tests = 0;
  int fails = 0;

  dsp_decim_fifo #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .decim_factor (decim_factor),
    .threshold    (threshold),
    .in_valid     (in_valid),
    .in_sample    (in_sample),
    .rd_en        (rd_en),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .level        (level),
    .empty        (empty),
    .full         (full),
    .thr_flag     (thr_flag),
    .ovf          (ovf),
`ifdef DSP_DECIM_FIFO_DROP_CNT_EN
    .drop_cnt     (drop_cnt),
`endif
    .ovf_clr      (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_drop(input string name, input int exp);
`ifdef DSP_DECIM_FIFO_DROP_CNT_EN
    check(name, 32'(drop_cnt), 32'(exp));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic iv, input logic [15:0] smp,
                       input logic re, input logic clr);
    enable    = en;
    in_valid  = iv;
    in_sample = smp;
    rd_en     = re;
    ovf_clr   = clr;
    tick();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_level"}, 32'(level), 0);
    check({tag, "_empty"}, 32'(empty), 1);
    check({tag, "_full"}, 32'(full), 0);
    check({tag, "_thr"}, 32'(thr_flag), 0);
    check({tag, "_rd_valid"}, 32'(rd_valid), 0);
    check({tag, "_rd_data"}, 32'(rd_data), 0);
    check({tag, "_ovf"}, 32'(ovf), 0);
    check_drop({tag, "_drop_cnt"}, 0);
  endtask

  // Reset lands between clock edges; outputs must respond without waiting for a clock.
  task automatic async_reset(input string tag);
    enable   = 1'b1;
    in_valid = 1'b0;
    rd_en    = 1'b0;
    ovf_clr  = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_state(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference model: a plain queue plus a sample counter.
  logic [15:0] mq[$];
  int          mdcnt;
  bit          movf;
  bit          mrv;
  logic [15:0] mrd;
  int          mdrop;

  task automatic model_reset();
    mq.delete();
    mdcnt = 0;
    movf  = 0;
    mrv   = 0;
    mrd   = 16'd0;
    mdrop = 0;
  endtask

  task automatic model_step(input logic en, input logic iv, input logic [15:0] smp,
                            input logic re, input logic clr, input logic [7:0] df);
    bit popok;
    bit keep;
    bit drop;
    int effn;
    drop = 0;
    if (!en) begin
      mq.delete();
      mdcnt = 0;
      mrv   = 0;
    end else begin
      popok = re && (mq.size() > 0);
      keep  = iv && (mdcnt == 0);
      effn  = (df == 0) ? 1 : int'(df);
      if (iv) mdcnt = (mdcnt >= effn - 1) ? 0 : mdcnt + 1;
      drop = keep && (mq.size() == DEPTH) && !popok;
      mrv  = popok;
      if (popok) mrd = mq.pop_front();
      if (keep && !drop) mq.push_back(smp);
    end
    if (drop) movf = 1;
    else if (clr) movf = 0;
    if (drop) mdrop = clr ? 1 : ((mdrop == 65535) ? 65535 : mdrop + 1);
    else if (clr) mdrop = 0;
  endtask

  typedef struct {
    logic        iv;
    logic [15:0] smp;
    logic        re;
    int          exp_level;
    logic        exp_rv;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic        en;
    logic        iv;
    logic        re;
    logic        clr;
    logic [15:0] smp;

    rst_n        = 1'b1;
    enable       = 1'b0;
    decim_factor = 8'd4;
    threshold    = '0;
    in_valid     = 1'b0;
    in_sample    = 16'd0;
    rd_en        = 1'b0;
    ovf_clr      = 1'b0;
    #1;
    rst_n = 1'b0;
    #2;
    check_reset_state("reset");
    @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b1;

    // Decimate by 4, drain, then empty-side corners.
    for (int i = 0; i < 16; i++) vecs.push_back('{1'b1, 16'(i), 1'b0, i / 4 + 1, 1'b0, 16'd0});
    for (int i = 0; i < 4; i++) vecs.push_back('{1'b0, 16'd0, 1'b1, 3 - i, 1'b1, 16'(4 * i)});
    vecs.push_back('{1'b0, 16'd0, 1'b0, 0, 1'b0, 16'd12});
    vecs.push_back('{1'b0, 16'd0, 1'b1, 0, 1'b0, 16'd12});
    vecs.push_back('{1'b1, 16'd7, 1'b1, 1, 1'b0, 16'd12});
    vecs.push_back('{1'b0, 16'd0, 1'b1, 0, 1'b1, 16'd7});
    foreach (vecs[k]) begin
      drive(1'b1, vecs[k].iv, vecs[k].smp, vecs[k].re, 1'b0);
      check($sformatf("vec%0d_level", k), 32'(level), 32'(vecs[k].exp_level));
      check($sformatf("vec%0d_empty", k), 32'(empty), 32'(vecs[k].exp_level == 0));
      check($sformatf("vec%0d_rd_valid", k), 32'(rd_valid), 32'(vecs[k].exp_rv));
      check($sformatf("vec%0d_rd_data", k), 32'(rd_data), 32'(vecs[k].exp_rd));
    end

    // Overflow: 66 pushes into 64 entries.
    async_reset("rst_a");
    decim_factor = 8'd1;
    for (int i = 0; i < 66; i++) drive(1'b1, 1'b1, 16'(100 + i), 1'b0, 1'b0);
    check("ovf_full", 32'(full), 1);
    check("ovf_set", 32'(ovf), 1);
    check("ovf_level", 32'(level), 64);
    check_drop("ovf_drop_cnt", 2);
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, 1'b0, 16'd0, 1'b1, 1'b0);
      check($sformatf("ovf_pop%0d", i), 32'(rd_data), 32'(100 + i));
    end
    check("ovf_drained_empty", 32'(empty), 1);
    drive(1'b1, 1'b0, 16'd0, 1'b0, 1'b1);
    check("ovf_cleared", 32'(ovf), 0);
    check_drop("ovf_drop_cleared", 0);

    // Push and pop together at the full boundary.
    async_reset("rst_b");
    for (int i = 0; i < 64; i++) drive(1'b1, 1'b1, 16'(200 + i), 1'b0, 1'b0);
    check("bnd_full", 32'(full), 1);
    drive(1'b1, 1'b1, 16'd500, 1'b1, 1'b0);
    check("bnd_level", 32'(level), 64);
    check("bnd_ovf", 32'(ovf), 0);
    check("bnd_rd_valid", 32'(rd_valid), 1);
    check("bnd_rd_data", 32'(rd_data), 200);
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, 1'b0, 16'd0, 1'b1, 1'b0);
      check($sformatf("bnd_pop%0d", i), 32'(rd_data), (i == 63) ? 32'd500 : 32'(201 + i));
    end
    check("bnd_empty", 32'(empty), 1);

    // Threshold edges with decim_factor 0 keeping every sample.
    async_reset("rst_c");
    decim_factor = 8'd0;
    threshold    = 7'd3;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 16'(40 + i), 1'b0, 1'b0);
      check($sformatf("thr_push%0d", i), 32'(thr_flag), 32'(i == 2));
    end
    check("thr_level", 32'(level), 3);
    drive(1'b1, 1'b0, 16'd0, 1'b1, 1'b0);
    check("thr_fall", 32'(thr_flag), 0);
    threshold = 7'd2;
    #1;
    check("thr_equal", 32'(thr_flag), 1);
    threshold = 7'd0;
    #1;
    check("thr_zero", 32'(thr_flag), 0);

    // Disable mid-run with level 10 and the counter part-way through a period.
    async_reset("rst_d");
    decim_factor = 8'd1;
    for (int i = 0; i < 65; i++) drive(1'b1, 1'b1, 16'(300 + i), 1'b0, 1'b0);
    for (int i = 0; i < 55; i++) drive(1'b1, 1'b0, 16'd0, 1'b1, 1'b0);
    decim_factor = 8'd3;
    drive(1'b1, 1'b1, 16'd900, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 16'd901, 1'b0, 1'b0);
    check("dis_pre_level", 32'(level), 10);
    drive(1'b0, 1'b1, 16'd902, 1'b1, 1'b0);
    check("dis_level", 32'(level), 0);
    check("dis_empty", 32'(empty), 1);
    check("dis_ovf_held", 32'(ovf), 1);
    check("dis_rd_valid", 32'(rd_valid), 0);
    check("dis_rd_data_held", 32'(rd_data), 354);
    drive(1'b1, 1'b1, 16'd77, 1'b0, 1'b0);
    check("reen_kept", 32'(level), 1);
    drive(1'b1, 1'b0, 16'd0, 1'b1, 1'b0);
    check("reen_pop", 32'(rd_data), 77);

    // Randomized run against the reference model.
    async_reset("rst_e");
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) decim_factor = 8'($urandom_range(0, 4));
      if (c % 300 == 0) threshold = 7'($urandom_range(0, DEPTH));
      en  = ($urandom_range(0, 199) != 0);
      iv  = ($urandom_range(0, 99) < 80);
      re  = ((c / 400) % 2 == 1) ? ($urandom_range(0, 99) < 75) : ($urandom_range(0, 99) < 5);
      clr = ($urandom_range(0, 99) < 3);
      smp = 16'($urandom);
      model_step(en, iv, smp, re, clr, decim_factor);
      drive(en, iv, smp, re, clr);
      check($sformatf("rnd%0d_level", c), 32'(level), 32'(mq.size()));
      check($sformatf("rnd%0d_empty", c), 32'(empty), 32'(mq.size() == 0));
      check($sformatf("rnd%0d_full", c), 32'(full), 32'(mq.size() == DEPTH));
      check($sformatf("rnd%0d_thr", c), 32'(thr_flag),
            32'((threshold != 0) && (mq.size() >= int'(threshold))));
      check($sformatf("rnd%0d_rd_valid", c), 32'(rd_valid), 32'(mrv));
      check($sformatf("rnd%0d_rd_data", c), 32'(rd_data), 32'(mrd));
      check($sformatf("rnd%0d_ovf", c), 32'(ovf), 32'(movf));
      check_drop($sformatf("rnd%0d_drop_cnt", c), mdrop);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
